// File: rtl/scoreboard_if.sv
// Decode/execute hazard-tracking bus between the pipeline and the register scoreboard.
// The pipeline side (master) drives decode, flush and completion; the scoreboard answers with stall and status.
interface scoreboard_if;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  RdD;
  logic        RegWriteD;
  logic        LongOpD;
  logic        ValidD;
  logic        FlushE;
  logic        CompleteValid;
  logic [4:0]  CompleteRd;
  logic        StallD;
  logic [31:0] Busy;
  logic [2:0]  OutCount;
  logic        Err;

  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, LongOpD, ValidD, FlushE,
           CompleteValid, CompleteRd,
    input  StallD, Busy, OutCount, Err
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, LongOpD, ValidD, FlushE,
           CompleteValid, CompleteRd,
    output StallD, Busy, OutCount, Err
  );
endinterface

// File: rtl/scoreboard.sv
// Register scoreboard for long-latency writes: tracks pending destinations, raises decode
// stalls on RAW/WAW/capacity hazards, and handles cancel of the last issue plus completions.
module scoreboard #(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  scoreboard_if.slave sb
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

  logic [31:0] busy_reg, busy_next;
  logic [31:0] set_vec, clr_vec;
  logic [2:0]  out_count_reg, out_count_next;
  logic [4:0]  last_rd_reg, last_rd_next;
  logic        last_valid_reg, last_valid_next;
  logic        err_reg, err_next;

  logic raw_hazard, waw_hazard, cap_hazard, stall;
  logic issue, cancel, comp_ok;

  // Hazards look only at registered state, so a completion never releases a stall in its own cycle.
  assign raw_hazard = sb.ValidD &
                      (((sb.Rs1D != 5'd0) && busy_reg[sb.Rs1D]) ||
                       ((sb.Rs2D != 5'd0) && busy_reg[sb.Rs2D]));
  assign waw_hazard = sb.ValidD & sb.RegWriteD & (sb.RdD != 5'd0) & busy_reg[sb.RdD];
  assign cap_hazard = sb.ValidD & sb.RegWriteD & sb.LongOpD & (out_count_reg == MAX_CNT);
  assign stall      = raw_hazard | waw_hazard | cap_hazard;

  assign issue   = sb.ValidD & ~stall & sb.RegWriteD & sb.LongOpD & (sb.RdD != 5'd0);
  assign cancel  = sb.FlushE & last_valid_reg;
  assign comp_ok = sb.CompleteValid & (sb.CompleteRd != 5'd0) & busy_reg[sb.CompleteRd];

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign set_vec[gi]   = 1'b0;
        assign clr_vec[gi]   = 1'b0;
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign set_vec[gi]   = issue && (sb.RdD == 5'(gi));
        // Cancel and completion on the same register simply both clear this one bit.
        assign clr_vec[gi]   = (cancel && (last_rd_reg == 5'(gi))) ||
                               (comp_ok && (sb.CompleteRd == 5'(gi)));
        assign busy_next[gi] = (busy_reg[gi] & ~clr_vec[gi]) | set_vec[gi];
      end
    end
  endgenerate

  always_comb begin
    out_count_next  = 3'($countones(busy_next));
    last_valid_next = issue;
    last_rd_next    = issue ? sb.RdD : last_rd_reg;
    err_next        = err_reg | (sb.CompleteValid & ~comp_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg       <= '0;
      out_count_reg  <= '0;
      last_rd_reg    <= '0;
      last_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      busy_reg       <= busy_next;
      out_count_reg  <= out_count_next;
      last_rd_reg    <= last_rd_next;
      last_valid_reg <= last_valid_next;
      err_reg        <= err_next;
    end
  end

  assign sb.StallD   = stall;
  assign sb.Busy     = busy_reg;
  assign sb.OutCount = out_count_reg;
  assign sb.Err      = err_reg;

endmodule

// File: tb/tb_scoreboard.sv
// Table-driven bench for the register scoreboard: each vector checks StallD before the edge
// and the queued post-edge Busy/OutCount/Err after it; reset corners are hand-written.
module tb_scoreboard;

  logic clk = 1'b0;
  logic rst_n;

  scoreboard_if sb_if ();

  scoreboard #(.MAX_OUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        lo;
    logic        fl;
    logic        cv;
    logic [4:0]  crd;
    logic        exp_stall;
    logic [31:0] exp_busy;
    logic [2:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] busy;
    logic [2:0]  cnt;
    logic        err;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_txn = 0;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic rw, input logic lo,
                              input logic fl, input logic cv, input logic [4:0] crd,
                              input logic st, input logic [31:0] busy, input logic [2:0] cnt,
                              input logic err);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rw = rw; t.lo = lo;
    t.fl = fl; t.cv = cv; t.crd = crd;
    t.exp_stall = st; t.exp_busy = busy; t.exp_cnt = cnt; t.exp_err = err;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (txn %0d)", name, act, exp, n_txn);
    end
  endtask

  task automatic drive_idle();
    sb_if.Rs1D = '0; sb_if.Rs2D = '0; sb_if.RdD = '0;
    sb_if.RegWriteD = 1'b0; sb_if.LongOpD = 1'b0; sb_if.ValidD = 1'b0;
    sb_if.FlushE = 1'b0; sb_if.CompleteValid = 1'b0; sb_if.CompleteRd = '0;
  endtask

  task automatic apply(input vec_t t);
    exp_t e;
    @(negedge clk);
    sb_if.ValidD = t.v; sb_if.Rs1D = t.rs1; sb_if.Rs2D = t.rs2; sb_if.RdD = t.rd;
    sb_if.RegWriteD = t.rw; sb_if.LongOpD = t.lo; sb_if.FlushE = t.fl;
    sb_if.CompleteValid = t.cv; sb_if.CompleteRd = t.crd;
    #1;
    check("stall", 32'(sb_if.StallD), 32'(t.exp_stall));
    exp_q.push_back('{busy: t.exp_busy, cnt: t.exp_cnt, err: t.exp_err});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("busy", sb_if.Busy, e.busy);
    check("outcount", 32'(sb_if.OutCount), 32'(e.cnt));
    check("err", 32'(sb_if.Err), 32'(e.err));
    $display("txn %0d: v=%0b rd=%0d fl=%0b cv=%0b crd=%0d -> busy=%08h cnt=%0d err=%0b",
             n_txn, t.v, t.rd, t.fl, t.cv, t.crd, sb_if.Busy, sb_if.OutCount, sb_if.Err);
    n_txn++;
  endtask

  // Shorthands: long-op issue, plain read, completion-only.
  function automatic vec_t iss(input logic [4:0] rd, input logic st, input logic [31:0] b,
                               input logic [2:0] c, input logic er);
    return mk(1, 0, 0, rd, 1, 1, 0, 0, 0, st, b, c, er);
  endfunction

  function automatic vec_t cmp(input logic [4:0] crd, input logic [31:0] b,
                               input logic [2:0] c, input logic er);
    return mk(0, 0, 0, 0, 0, 0, 0, 1, crd, 0, b, c, er);
  endfunction

  initial begin
    rst_n = 1'b0;
    drive_idle();
    #12;
    check("rst_busy", sb_if.Busy, 32'h0);
    check("rst_cnt", 32'(sb_if.OutCount), 32'd0);
    check("rst_err", 32'(sb_if.Err), 32'd0);
    check("rst_stall", 32'(sb_if.StallD), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RAW on x5, released one cycle after the completion edge
    tbl.push_back(iss(5, 0, 32'h20, 1, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 1, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 1, 5, 1, 32'h0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    // long op to x0
    tbl.push_back(iss(0, 0, 32'h0, 0, 0));
    // capacity: x1..x4 then x6 stalls until a completion
    tbl.push_back(iss(1, 0, 32'h02, 1, 0));
    tbl.push_back(iss(2, 0, 32'h06, 2, 0));
    tbl.push_back(iss(3, 0, 32'h0E, 3, 0));
    tbl.push_back(iss(4, 0, 32'h1E, 4, 0));
    tbl.push_back(iss(6, 1, 32'h1E, 4, 0));
    tbl.push_back(iss(6, 1, 32'h1E, 4, 0));
    tbl.push_back(mk(1, 0, 0, 6, 1, 1, 0, 1, 1, 1, 32'h1C, 3, 0));
    tbl.push_back(iss(6, 0, 32'h5C, 4, 0));
    tbl.push_back(cmp(2, 32'h58, 3, 0));
    tbl.push_back(cmp(3, 32'h50, 2, 0));
    tbl.push_back(cmp(4, 32'h40, 1, 0));
    tbl.push_back(cmp(6, 32'h00, 0, 0));
    // cancel of x7
    tbl.push_back(iss(7, 0, 32'h80, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0));
    // cancel and completion on the same register
    tbl.push_back(iss(8, 0, 32'h100, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 8, 0, 32'h0, 0, 0));
    // cancel and completion on different registers
    tbl.push_back(iss(10, 0, 32'h400, 1, 0));
    tbl.push_back(iss(11, 0, 32'hC00, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 10, 0, 32'h0, 0, 0));
    // flush without a preceding issue changes nothing
    tbl.push_back(iss(12, 0, 32'h1000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h1000, 1, 0));
    tbl.push_back(cmp(12, 32'h0, 0, 0));
    // WAW stall on x13 (short op)
    tbl.push_back(iss(13, 0, 32'h2000, 1, 0));
    tbl.push_back(mk(1, 0, 0, 13, 1, 0, 0, 0, 0, 1, 32'h2000, 1, 0));
    tbl.push_back(cmp(13, 32'h0, 0, 0));
    // RAW via Rs2, then issue concurrent with completion
    tbl.push_back(iss(14, 0, 32'h4000, 1, 0));
    tbl.push_back(mk(1, 0, 14, 0, 0, 0, 0, 0, 0, 1, 32'h4000, 1, 0));
    tbl.push_back(mk(1, 0, 0, 15, 1, 1, 0, 1, 14, 0, 32'h8000, 1, 0));
    tbl.push_back(cmp(15, 32'h0, 0, 0));
    // completion of a non-busy register: sticky error
    tbl.push_back(cmp(9, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1));
    tbl.push_back(cmp(0, 32'h0, 0, 1));

    foreach (tbl[i]) apply(tbl[i]);

    // Mid-stream asynchronous reset with three pending entries
    apply(iss(1, 0, 32'h02, 1, 1));
    apply(iss(2, 0, 32'h06, 2, 1));
    apply(iss(3, 0, 32'h0E, 3, 1));
    #2;
    sb_if.ValidD = 1'b1; sb_if.Rs1D = 5'd1; sb_if.RegWriteD = 1'b0; sb_if.LongOpD = 1'b0;
    #1;
    check("pre_rst_stall", 32'(sb_if.StallD), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", sb_if.Busy, 32'h0);
    check("async_rst_cnt", 32'(sb_if.OutCount), 32'd0);
    check("async_rst_err", 32'(sb_if.Err), 32'd0);
    check("async_rst_stall", 32'(sb_if.StallD), 32'd0);
    $display("txn %0d: async reset -> busy=%08h cnt=%0d err=%0b",
             n_txn, sb_if.Busy, sb_if.OutCount, sb_if.Err);
    n_txn++;
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    // late completion of an entry discarded by reset
    apply(cmp(1, 32'h0, 0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scoreboard.md
SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 The block SHALL have one parameter: MAX_OUT, default 4, maximum outstanding long-latency writes (legal range 1..7).
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- Rs1D  input  5  decode-stage source register 1.
- Rs2D  input  5  decode-stage source register 2.
- RdD  input  5  decode-stage destination register.
- RegWriteD  input  1  decode instruction writes RdD.
- LongOpD  input  1  decode instruction is multi-cycle; its result returns on the completion port.
- ValidD  input  1  decode stage holds a real instruction.
- FlushE  input  1  cancel the instruction that left decode in the previous cycle.
- CompleteValid  input  1  a long-latency result is written back this cycle.
- CompleteRd  input  5  destination of the completing result.
- StallD  output  1  hold the decode stage.
- Busy  output  32  per-register pending-write bits; bit 0 constantly 0.
- OutCount  output  3  number of set Busy bits.
- Err  output  1  sticky protocol-error flag.

Function
REQ-003 Hazards SHALL be computed combinationally from the registered Busy bits; a completion does not bypass into StallD in the same cycle.
- RAW: ValidD and Busy[Rs1D] or Busy[Rs2D], register 0 excluded.
- WAW: ValidD and RegWriteD and Busy[RdD], RdD != 0.
- Capacity: ValidD and RegWriteD and LongOpD and OutCount == MAX_OUT.
REQ-004 StallD SHALL be the OR of the three hazard terms in REQ-003.
REQ-005 Issue SHALL be defined as ValidD & ~StallD & RegWriteD & LongOpD & (RdD != 0).
REQ-006 On issue, Busy[RdD] SHALL set at the next edge.
REQ-007 On issue, the block SHALL record LastRd = RdD and LastValid = 1; otherwise LastValid SHALL be 0 at that edge.
REQ-008 On FlushE & LastValid, Busy[LastRd] SHALL clear at the next edge (cancel).
REQ-009 On FlushE with LastValid = 0, the block SHALL make no change.
REQ-010 On CompleteValid with Busy[CompleteRd] = 1, Busy[CompleteRd] SHALL clear at the next edge.
REQ-011 On CompleteValid with CompleteRd = 0 or Busy[CompleteRd] = 0, the block SHALL leave state unchanged and set Err.
REQ-012 When cancel and completion target the same register in one cycle, the bit SHALL clear once, OutCount SHALL decrement by 1, and Err SHALL NOT set.
REQ-013 When cancel and completion target different registers, both bits SHALL clear and OutCount SHALL decrement by 2.
REQ-014 An issue in the same cycle as a cancel or completion SHALL apply both, and OutCount SHALL change by the net amount.
- An issue cannot target a Busy register (WAW stall).
- A cancel clears only a bit set by the previous cycle's issue.
REQ-015 OutCount SHALL always equal the population count of Busy and SHALL never exceed MAX_OUT; neither underflow nor overflow is reachable.
REQ-016 Err SHALL remain set until reset.
REQ-017 Issue latency SHALL be one cycle: an instruction reading RdD is stalled starting the cycle after issue.
REQ-018 Release latency SHALL be one cycle: StallD drops the cycle after the completion or cancel edge.

Reset
REQ-019 While rst_n is low, the block SHALL immediately force Busy = 0, OutCount = 0, LastValid = 0 and Err = 0, independent of clk.
REQ-020 While rst_n is low, StallD SHALL be 0 because Busy is 0.
REQ-021 An assertion of rst_n mid-operation SHALL discard all pending entries, and late completions arriving after reset SHALL set Err.
REQ-022 After rst_n is released, the first state update SHALL occur on the next rising edge of clk.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Issue RdD=5 as a long op, then Rs1D=5 next cycle -> StallD=1, Busy[5]=1, OutCount=1. CompleteValid with CompleteRd=5 -> StallD=0 one cycle after the completion edge.
- Issue a long op to x0 -> no Busy change, OutCount=0, no stall.
- Issue long ops to x1..x4 (MAX_OUT=4), then a fifth long op to x6 -> StallD=1 until any completion, then issue proceeds and OutCount stays 4.
- Issue x7, then FlushE next cycle -> Busy[7]=0, OutCount=0, Err=0.
- Issue x8, then next cycle FlushE and CompleteValid with CompleteRd=8 -> OutCount=0, Err=0.
- Complete x9 while not busy -> Err=1 and stays set.
- Pulse rst_n low mid-stream with 3 entries pending -> Busy=0 and OutCount=0 immediately. A later completion -> Err=1.
